// File: rtl/load_unit_if.sv
// Bundle of the core request, data-memory read and response channels used by
// load_unit. The slave modport is the load unit's own view; the master
// modport is the surrounding core plus data memory.
interface load_unit_if;
   // core -> unit request channel
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_funct3;
   logic [4:0]  req_rd;

   // unit <-> data memory read channel
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   // unit -> core response channel
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_rd;
   logic        rsp_err;

   // status
   logic        busy;

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_funct3,
      input  req_rd,
      output req_ready,
      output mem_rd_en,
      output mem_addr,
      input  mem_rvalid,
      input  mem_rdata,
      output rsp_valid,
      input  rsp_ready,
      output rsp_data,
      output rsp_rd,
      output rsp_err,
      output busy
   );

   modport master (
      output req_valid,
      output req_addr,
      output req_funct3,
      output req_rd,
      input  req_ready,
      input  mem_rd_en,
      input  mem_addr,
      output mem_rvalid,
      output mem_rdata,
      input  rsp_valid,
      output rsp_ready,
      input  rsp_data,
      input  rsp_rd,
      input  rsp_err,
      input  busy
   );
endinterface

// File: rtl/load_unit.sv
// Load unit: takes one load request at a time, issues a single word-aligned
// read to data memory, waits for the read data under a timeout, then selects
// and sign/zero-extends the addressed byte or half and returns it over a
// valid/ready response channel. Misaligned and illegal requests are answered
// with an error without touching memory; a memory that never answers is
// answered with an error after TIMEOUT wait cycles.
module load_unit #(
   parameter int TIMEOUT = 255   // wait cycles before abort, 1..1023
) (
   input  logic   clk,
   input  logic   rst_n,
   load_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Counter value on the last permitted wait cycle; reaching it without
   // read data aborts the access.
   localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

   state_t      state_reg;
   state_t      state_next;

   // Request fields latched at accept; only the byte offset is needed after
   // the read address has been formed.
   logic [1:0]  off_reg;
   logic [2:0]  funct3_reg;

   logic [9:0]  cnt_reg;
   logic [31:0] mem_addr_reg;
   logic [31:0] rsp_data_reg;
   logic [4:0]  rsp_rd_reg;
   logic        rsp_err_reg;

   // Request-side decode
   logic        req_fire;
   logic        req_illegal;
   logic        req_misaligned;
   logic        req_bad;

   // Memory-side decode
   logic        wait_hit;
   logic        wait_expire;

   // Lane selection / extension
   logic [7:0]  byte_lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;

   // State-decoded outputs
   logic        req_ready_dec;
   logic        mem_rd_en_dec;
   logic        rsp_valid_dec;
   logic        busy_dec;

   // ------------------------------------------------------------------
   // Byte lanes of the returned word, lane gi = bits [8*gi+7 : 8*gi]
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign byte_lane[gi] = bus.mem_rdata[8*gi +: 8];
      end
   endgenerate

   // Classify the incoming request as illegal or misaligned.
   always_comb begin
      req_fire       = (state_reg == IDLE) && bus.req_valid;
      req_illegal    = 1'b0;
      req_misaligned = 1'b0;
      unique case (bus.req_funct3)
         F3_LB, F3_LBU: req_misaligned = 1'b0;
         F3_LH, F3_LHU: req_misaligned = bus.req_addr[0];
         F3_LW:         req_misaligned = (bus.req_addr[1:0] != 2'b00);
         default:       req_illegal    = 1'b1;
      endcase
      req_bad = req_illegal || req_misaligned;
   end

   // Read data is only meaningful in WAIT; data has priority over expiry.
   always_comb begin
      wait_hit    = (state_reg == WAIT) && bus.mem_rvalid;
      wait_expire = (state_reg == WAIT) && !bus.mem_rvalid && (cnt_reg == CNT_LAST);
   end

   // Select the addressed lane of the read word and extend it to 32 bits.
   always_comb begin
      byte_sel = byte_lane[off_reg];
      half_sel = off_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      load_ext = 32'h0000_0000;
      unique case (funct3_reg)
         F3_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
         F3_LW:   load_ext = bus.mem_rdata;
         F3_LBU:  load_ext = {24'h00_0000, byte_sel};
         F3_LHU:  load_ext = {16'h0000, half_sel};
         default: load_ext = 32'h0000_0000;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: begin
            if (bus.req_valid) begin
               state_next = req_bad ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            state_next = WAIT;
         end
         WAIT: begin
            if (wait_hit || wait_expire) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Handshake and strobe outputs decoded from the current state only.
   always_comb begin
      req_ready_dec = 1'b0;
      mem_rd_en_dec = 1'b0;
      rsp_valid_dec = 1'b0;
      busy_dec      = 1'b1;
      unique case (state_reg)
         IDLE: begin
            req_ready_dec = 1'b1;
            busy_dec      = 1'b0;
         end
         ISSUE: begin
            mem_rd_en_dec = 1'b1;
         end
         WAIT: begin
            busy_dec      = 1'b1;
         end
         RESP: begin
            rsp_valid_dec = 1'b1;
         end
         default: begin
            busy_dec      = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------

   // Latch request fields on accept; the read address only changes when a
   // real memory access is about to be issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         off_reg      <= 2'b00;
         funct3_reg   <= 3'b000;
         mem_addr_reg <= 32'h0000_0000;
         rsp_rd_reg   <= 5'd0;
      end else if (req_fire) begin
         off_reg    <= bus.req_addr[1:0];
         funct3_reg <= bus.req_funct3;
         rsp_rd_reg <= bus.req_rd;
         if (!req_bad) begin
            mem_addr_reg <= {bus.req_addr[31:2], 2'b00};
         end
      end
   end

   // Wait-cycle counter: cleared while the read is issued, counts empty WAIT cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= 10'd0;
      end else if (state_reg == ISSUE) begin
         cnt_reg <= 10'd0;
      end else if ((state_reg == WAIT) && !bus.mem_rvalid && (cnt_reg != CNT_LAST)) begin
         cnt_reg <= cnt_reg + 10'd1;
      end
   end

   // Response payload: written when entering RESP, then held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data_reg <= 32'h0000_0000;
         rsp_err_reg  <= 1'b0;
      end else if (req_fire && req_bad) begin
         rsp_data_reg <= 32'h0000_0000;
         rsp_err_reg  <= 1'b1;
      end else if (wait_hit) begin
         rsp_data_reg <= load_ext;
         rsp_err_reg  <= 1'b0;
      end else if (wait_expire) begin
         rsp_data_reg <= 32'h0000_0000;
         rsp_err_reg  <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Output drive
   // ------------------------------------------------------------------
   assign bus.req_ready = req_ready_dec;
   assign bus.mem_rd_en = mem_rd_en_dec;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.rsp_valid = rsp_valid_dec;
   assign bus.rsp_data  = rsp_data_reg;
   assign bus.rsp_rd    = rsp_rd_reg;
   assign bus.rsp_err   = rsp_err_reg;
   assign bus.busy      = busy_dec;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: a table of load transactions with
// hand-computed results, plus hand-written reset sequences.
module tb_load_unit;

   localparam int TO = 4;

   logic clk;
   logic rst_n;
   load_unit_if bus();

   load_unit #(.TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [4:0]  rd;
      logic [31:0] rdata;
      int          k;          // cycle (after accept) carrying mem_rvalid, 0 = never
      int          hold;       // cycles rsp_ready stays low in RESP
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_lat;    // cycles from accept to rsp_valid
      int          exp_pulses; // number of mem_rd_en cycles
      logic [31:0] exp_maddr;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {bus.req_ready, bus.mem_rd_en, bus.mem_addr, bus.rsp_valid,
                   bus.rsp_data, bus.rsp_rd, bus.rsp_err, bus.busy},
                  {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0});
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      int   c;
      int   pulses;
      logic [31:0] maddr;
      bit   got;
      v = vecs[i];

      check($sformatf("v%0d_req_ready", i), bus.req_ready, 1'b1);
      bus.req_valid  = 1'b1;
      bus.req_addr   = v.addr;
      bus.req_funct3 = v.f3;
      bus.req_rd     = v.rd;
      step();
      bus.req_valid  = 1'b0;
      bus.req_addr   = 32'hFFFF_FFFF;
      bus.req_funct3 = 3'b111;
      bus.req_rd     = 5'd0;

      c = 1; pulses = 0; got = 0; maddr = 32'h0;
      while (!got && c < 40) begin
         if (bus.rsp_valid) begin
            got = 1;
         end else begin
            if (bus.mem_rd_en) begin
               pulses++;
               maddr = bus.mem_addr;
            end
            bus.mem_rvalid = (v.k != 0) && (c == v.k);
            bus.mem_rdata  = v.rdata;
            step();
            c++;
         end
      end
      bus.mem_rvalid = 1'b0;

      check($sformatf("v%0d_rsp_seen", i), got, 1'b1);
      check($sformatf("v%0d_latency", i), c, v.exp_lat);
      check($sformatf("v%0d_rd_pulses", i), pulses, v.exp_pulses);
      if (v.exp_pulses != 0)
         check($sformatf("v%0d_mem_addr", i), maddr, v.exp_maddr);
      check($sformatf("v%0d_rsp_data", i), bus.rsp_data, v.exp_data);
      check($sformatf("v%0d_rsp_err", i), bus.rsp_err, v.exp_err);
      check($sformatf("v%0d_rsp_rd", i), bus.rsp_rd, v.rd);

      // Back-pressure with stray read data present: response must hold.
      for (int h = 0; h < v.hold; h++) begin
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = 32'hBAD0_0000 | 32'(h);
         step();
         check($sformatf("v%0d_hold%0d", i, h),
               {bus.rsp_valid, bus.req_ready, bus.rsp_data, bus.rsp_rd, bus.rsp_err},
               {1'b1, 1'b0, v.exp_data, v.rd, v.exp_err});
      end
      bus.mem_rvalid = 1'b0;

      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      check($sformatf("v%0d_after_hs", i), {bus.rsp_valid, bus.busy, bus.req_ready}, 3'b001);

      // Stray read data while idle must not create a response.
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h5555_AAAA;
      step();
      bus.mem_rvalid = 1'b0;
      check($sformatf("v%0d_idle_stray", i), {bus.rsp_valid, bus.busy, bus.req_ready}, 3'b001);

      $display("[TB] vec %0d f3=%b addr=0x%08h rd=%0d -> data=0x%08h err=%0b lat=%0d",
               i, v.f3, v.addr, v.rd, bus.rsp_data, bus.rsp_err, c);
   endtask

   initial begin
      //          f3      addr          rd     rdata          k  hold exp_data       err  lat pls maddr
      vecs[0]  = '{3'b000, 32'h0000_0103, 5'd1,  32'h80FF_1234, 2, 0, 32'hFFFF_FF80, 1'b0, 3, 1, 32'h0000_0100};
      vecs[1]  = '{3'b101, 32'h0000_0202, 5'd2,  32'h8001_F00F, 2, 1, 32'h0000_8001, 1'b0, 3, 1, 32'h0000_0200};
      vecs[2]  = '{3'b001, 32'h0000_0200, 5'd3,  32'h8001_F00F, 3, 0, 32'hFFFF_F00F, 1'b0, 4, 1, 32'h0000_0200};
      vecs[3]  = '{3'b010, 32'h0000_0006, 5'd4,  32'h1111_1111, 0, 0, 32'h0000_0000, 1'b1, 1, 0, 32'h0};
      vecs[4]  = '{3'b011, 32'h0000_0000, 5'd5,  32'h2222_2222, 0, 0, 32'h0000_0000, 1'b1, 1, 0, 32'h0};
      vecs[5]  = '{3'b100, 32'h0000_0301, 5'd6,  32'h1122_3344, 0, 2, 32'h0000_0000, 1'b1, 6, 1, 32'h0000_0300};
      vecs[6]  = '{3'b010, 32'h0000_0400, 5'd8,  32'hDEAD_BEEF, 2, 0, 32'hDEAD_BEEF, 1'b0, 3, 1, 32'h0000_0400};
      vecs[7]  = '{3'b010, 32'h0000_0010, 5'd7,  32'h1234_5678, 2, 5, 32'h1234_5678, 1'b0, 3, 1, 32'h0000_0010};
      vecs[8]  = '{3'b100, 32'h0000_0102, 5'd9,  32'h80FF_1234, 4, 0, 32'h0000_00FF, 1'b0, 5, 1, 32'h0000_0100};
      vecs[9]  = '{3'b000, 32'h0000_0100, 5'd10, 32'h80FF_1234, 2, 0, 32'h0000_0034, 1'b0, 3, 1, 32'h0000_0100};
      vecs[10] = '{3'b001, 32'h0000_0003, 5'd11, 32'h3333_3333, 0, 0, 32'h0000_0000, 1'b1, 1, 0, 32'h0};
      vecs[11] = '{3'b110, 32'h0000_0008, 5'd12, 32'h4444_4444, 0, 0, 32'h0000_0000, 1'b1, 1, 0, 32'h0};
      vecs[12] = '{3'b111, 32'h0000_000C, 5'd13, 32'h5555_5555, 0, 0, 32'h0000_0000, 1'b1, 1, 0, 32'h0};
      vecs[13] = '{3'b010, 32'h0000_0020, 5'd14, 32'hCAFE_F00D, 5, 0, 32'hCAFE_F00D, 1'b0, 6, 1, 32'h0000_0020};
      vecs[14] = '{3'b001, 32'h0000_0102, 5'd15, 32'h7FFF_0000, 2, 0, 32'h0000_7FFF, 1'b0, 3, 1, 32'h0000_0100};
      vecs[15] = '{3'b101, 32'h0000_0000, 5'd31, 32'h0000_ABCD, 2, 0, 32'h0000_ABCD, 1'b0, 3, 1, 32'h0000_0000};

      bus.req_valid  = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_funct3 = 3'b000;
      bus.req_rd     = 5'd0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h0;
      bus.rsp_ready  = 1'b0;
      rst_n          = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      $display("[TB] reset: req_ready=%0b busy=%0b rsp_valid=%0b", bus.req_ready, bus.busy, bus.rsp_valid);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < NV; i++) begin
         run_vec(i);
      end

      // Reset while waiting on memory: dropped at once, later data ignored.
      bus.req_valid  = 1'b1;
      bus.req_addr   = 32'h0000_0500;
      bus.req_funct3 = 3'b010;
      bus.req_rd     = 5'd9;
      step();
      bus.req_valid  = 1'b0;
      step();
      step();
      check("midreset_busy_before", {bus.busy, bus.rsp_valid, bus.mem_addr}, {1'b1, 1'b0, 32'h0000_0500});
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset_immediate");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h0BAD_F00D;
      step();
      bus.mem_rvalid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         check($sformatf("midreset_late_rvalid%0d", j), {bus.rsp_valid, bus.busy, bus.rsp_data}, {1'b0, 1'b0, 32'h0});
         step();
      end
      $display("[TB] midreset: rsp_valid=%0b busy=%0b rsp_data=0x%08h", bus.rsp_valid, bus.busy, bus.rsp_data);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
